// File: rtl/uart_tx_fifo.sv
// Byte FIFO feeding a UART transmitter one byte at a time.
// Optional sticky overflow flag: define UART_TX_FIFO_OVF_EN.
module uart_tx_fifo #(
  parameter int DEPTH_LOG2 = 4
) (
  input  logic                  SYS_CLK,
  input  logic                  RST_N,
  input  logic                  wr_en,
  input  logic [7:0]            wr_data,
  input  logic                  tx_busy,
  output logic                  tx_req,
  output logic [7:0]            tx_data,
  output logic                  full,
  output logic                  empty,
  output logic [DEPTH_LOG2:0]   level,
  output logic                  ovf_flag,
  input  logic                  ovf_clr
);

  localparam int DEPTH = 1 << DEPTH_LOG2;
  localparam logic [DEPTH_LOG2-1:0] PTR_ONE = DEPTH_LOG2'(1);
  localparam logic [DEPTH_LOG2:0]   LVL_ONE = (DEPTH_LOG2 + 1)'(1);

  typedef enum logic [1:0] {
    IDLE,
    REQ,
    WAIT_BUSY,
    WAIT_DONE
  } state_t;

  state_t state_q;
  state_t state_d;

  logic [7:0]            mem [DEPTH];
  logic [DEPTH_LOG2-1:0] rd_ptr;
  logic [DEPTH_LOG2-1:0] wr_ptr;
  logic [DEPTH_LOG2:0]   level_d;
  logic                  pop;
  logic                  acc;

  // Pop uses the registered empty, so a byte written this edge waits.
  assign pop = (state_q == IDLE) && !empty && !tx_busy;
  assign acc = wr_en && (!full || pop);

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:      if (!empty && !tx_busy) state_d = REQ;
      REQ:       state_d = WAIT_BUSY;
      WAIT_BUSY: if (tx_busy) state_d = WAIT_DONE;
      WAIT_DONE: if (!tx_busy) state_d = IDLE;
      default:   state_d = IDLE;
    endcase
  end

  always_comb begin
    level_d = level;
    unique case (1'b1)
      (acc && !pop): level_d = level + LVL_ONE;
      (pop && !acc): level_d = level - LVL_ONE;
      default:       level_d = level;
    endcase
  end

  always_ff @(posedge SYS_CLK) begin
    if (acc) mem[wr_ptr] <= wr_data;
  end

  always_ff @(posedge SYS_CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q <= IDLE;
      tx_req  <= 1'b0;
      tx_data <= 8'h00;
      rd_ptr  <= '0;
      wr_ptr  <= '0;
      level   <= '0;
      empty   <= 1'b1;
      full    <= 1'b0;
    end else begin
      state_q <= state_d;
      tx_req  <= pop;
      if (pop) begin
        tx_data <= mem[rd_ptr];
        rd_ptr  <= rd_ptr + PTR_ONE;
      end
      if (acc) wr_ptr <= wr_ptr + PTR_ONE;
      level <= level_d;
      empty <= (level_d == '0);
      full  <= level_d[DEPTH_LOG2];
    end
  end

`ifdef UART_TX_FIFO_OVF_EN
  logic drop;
  assign drop = wr_en && full && !pop;

  // A drop on the same edge as a clear wins.
  always_ff @(posedge SYS_CLK or negedge RST_N) begin
    if (!RST_N)       ovf_flag <= 1'b0;
    else if (drop)    ovf_flag <= 1'b1;
    else if (ovf_clr) ovf_flag <= 1'b0;
  end
`else
  logic unused_ovf_clr;
  assign unused_ovf_clr = ovf_clr;
  assign ovf_flag = 1'b0;
`endif

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Directed bench for uart_tx_fifo with a simple transmitter model.
// Overflow expectations follow UART_TX_FIFO_OVF_EN.
module tb_uart_tx_fifo;

`ifdef UART_TX_FIFO_OVF_EN
  localparam bit OVF = 1'b1;
`else
  localparam bit OVF = 1'b0;
`endif

  logic       clk;
  logic       rst_n;
  logic       wr_en;
  logic [7:0] wr_data;
  logic       tx_busy;
  logic       tx_req;
  logic [7:0] tx_data;
  logic       full;
  logic       empty;
  logic [4:0] level;
  logic       ovf_flag;
  logic       ovf_clr;

  logic d_busy;
  logic m_busy;
  logic model_en;
  logic pend;
  int   bcnt;
  logic prev_req;
  int   viol;
  logic [7:0] cap [$];

  int n_assert;
  int n_fail;
  int base;
  int v0;

  assign tx_busy = model_en ? m_busy : d_busy;

  uart_tx_fifo #(.DEPTH_LOG2(4)) dut (
    .SYS_CLK  (clk),
    .RST_N    (rst_n),
    .wr_en    (wr_en),
    .wr_data  (wr_data),
    .tx_busy  (tx_busy),
    .tx_req   (tx_req),
    .tx_data  (tx_data),
    .full     (full),
    .empty    (empty),
    .level    (level),
    .ovf_flag (ovf_flag),
    .ovf_clr  (ovf_clr)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Monitor plus transmitter: busy rises one cycle after tx_req, lasts 40.
  initial begin
    pend = 1'b0; bcnt = 0; m_busy = 1'b0; prev_req = 1'b0; viol = 0;
    forever begin
      @(negedge clk);
      if (tx_req) cap.push_back(tx_data);
      if (tx_req && (prev_req || tx_busy)) viol++;
      prev_req = tx_req;
      if (!model_en) begin
        pend = 1'b0; bcnt = 0; m_busy = 1'b0;
      end else begin
        if (pend) begin
          m_busy = 1'b1; bcnt = 40; pend = 1'b0;
        end else if (bcnt > 0) begin
          bcnt--;
          if (bcnt == 0) m_busy = 1'b0;
        end
        if (tx_req) pend = 1'b1;
      end
    end
  end

  task automatic step();
    @(posedge clk);
    @(negedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] cap_at(input int i);
    if (i < cap.size()) return {24'h0, cap[i]};
    return 32'hFFFF_FFFF;
  endfunction

  initial begin
    n_assert = 0; n_fail = 0;
    rst_n = 1'b0; wr_en = 1'b0; wr_data = 8'h00;
    d_busy = 1'b0; model_en = 1'b0; ovf_clr = 1'b0;
    repeat (3) step();
    chk("rst_req", tx_req, 0);
    chk("rst_data", tx_data, 0);
    chk("rst_level", level, 0);
    chk("rst_empty", empty, 1);
    chk("rst_full", full, 0);
    chk("rst_ovf", ovf_flag, 0);
    rst_n = 1'b1;
    step();

    // Single byte, no bypass, one-cycle request
    wr_en = 1'b1; wr_data = 8'hA5;
    step();
    wr_en = 1'b0;
    chk("a5_lvl1", level, 1);
    chk("a5_nobypass", tx_req, 0);
    step();
    chk("a5_req", tx_req, 1);
    chk("a5_data", tx_data, 8'hA5);
    chk("a5_lvl0", level, 0);
    chk("a5_empty", empty, 1);
    step();
    chk("a5_req_low", tx_req, 0);
    chk("a5_hold", tx_data, 8'hA5);
    d_busy = 1'b1; step();
    d_busy = 1'b0; step();

    // Fill to full while the transmitter is busy
    d_busy = 1'b1;
    for (int i = 1; i <= 16; i++) begin
      wr_en = 1'b1; wr_data = 8'(i);
      step();
    end
    wr_en = 1'b0;
    chk("fill_level", level, 16);
    chk("fill_full", full, 1);
    chk("fill_empty", empty, 0);
    chk("fill_noreq", tx_req, 0);

    // Overflow drop, set-beats-clear, then clear
    wr_en = 1'b1; wr_data = 8'hFF;
    step();
    wr_en = 1'b0;
    chk("ovf_level", level, 16);
    chk("ovf_set", ovf_flag, OVF);
    wr_en = 1'b1; ovf_clr = 1'b1;
    step();
    wr_en = 1'b0;
    chk("ovf_setclr", ovf_flag, OVF);
    step();
    ovf_clr = 1'b0;
    chk("ovf_clr", ovf_flag, 0);
    chk("ovf_level2", level, 16);

    // Full FIFO: pop and write 0x77 on one edge, then drain in order
    base = cap.size(); v0 = viol;
    model_en = 1'b1; d_busy = 1'b0;
    wr_en = 1'b1; wr_data = 8'h77;
    step();
    wr_en = 1'b0;
    chk("pw_level", level, 16);
    chk("pw_full", full, 1);
    chk("pw_req", tx_req, 1);
    chk("pw_data", tx_data, 8'h01);
    for (int c = 0; c < 2000 && cap.size() < base + 17; c++) step();
    repeat (50) step();
    chk("drain_count", cap.size() - base, 17);
    for (int i = 0; i < 16; i++)
      chk($sformatf("drain_%0d", i), cap_at(base + i), i + 1);
    chk("drain_last77", cap_at(base + 16), 8'h77);
    chk("drain_empty", empty, 1);
    chk("drain_level", level, 0);
    chk("drain_viol", viol - v0, 0);

    // Three bytes through the 40-cycle transmitter
    base = cap.size(); v0 = viol;
    for (int i = 0; i < 3; i++) begin
      wr_en = 1'b1; wr_data = 8'h11 * 8'(i + 1);
      step();
    end
    wr_en = 1'b0;
    repeat (250) step();
    chk("tx3_count", cap.size() - base, 3);
    chk("tx3_b0", cap_at(base), 8'h11);
    chk("tx3_b1", cap_at(base + 1), 8'h22);
    chk("tx3_b2", cap_at(base + 2), 8'h33);
    chk("tx3_viol", viol - v0, 0);

    // Reset during WAIT_DONE with five bytes queued
    for (int i = 0; i < 6; i++) begin
      wr_en = 1'b1; wr_data = 8'h41 + 8'(i);
      step();
    end
    wr_en = 1'b0;
    chk("mid_level", level, 5);
    repeat (5) step();
    model_en = 1'b0;
    rst_n = 1'b0;
    #1;
    chk("mrst_req", tx_req, 0);
    chk("mrst_data", tx_data, 0);
    chk("mrst_level", level, 0);
    chk("mrst_empty", empty, 1);
    chk("mrst_full", full, 0);
    chk("mrst_ovf", ovf_flag, 0);
    step();
    rst_n = 1'b1;
    model_en = 1'b1;
    base = cap.size();
    repeat (100) step();
    chk("post_rst_noreq", cap.size() - base, 0);
    chk("post_rst_empty", empty, 1);
    wr_en = 1'b1; wr_data = 8'h5A;
    step();
    wr_en = 1'b0;
    repeat (60) step();
    chk("post_rst_count", cap.size() - base, 1);
    chk("post_rst_data", cap_at(base), 8'h5A);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/uart_tx_fifo.md
UART_TX_FIFO -- requirements
Module: uart_tx_fifo

Interface
REQ-001 The block SHALL have parameter DEPTH_LOG2, default 4, giving FIFO depth 2**DEPTH_LOG2 bytes.
REQ-002 SYS_CLK  input  1  system clock; all state SHALL update on its rising edge.
REQ-003 RST_N  input  1  reset; asynchronous, active-low.
REQ-004 wr_en  input  1  write strobe; wr_data is sampled on the same edge.
REQ-005 wr_data  input  8  byte to enqueue.
REQ-006 tx_busy  input  1  transmitter busy flag from the downstream UART transmitter.
REQ-007 tx_req  output  1  one-cycle send request to the transmitter.
REQ-008 tx_data  output  8  byte presented to the transmitter; valid whenever tx_req=1.
REQ-009 full  output  1  high when level = 2**DEPTH_LOG2.
REQ-010 empty  output  1  high when level = 0.
REQ-011 level  output  DEPTH_LOG2+1  number of bytes stored.
REQ-012 ovf_flag  output  1  sticky overflow indicator (see Configuration).
REQ-013 ovf_clr  input  1  synchronous clear of ovf_flag.

Function
REQ-014 Storage SHALL be a circular buffer with rd_ptr and wr_ptr of DEPTH_LOG2 bits, wrapping from 2**DEPTH_LOG2-1 to 0.
REQ-015 A write SHALL be accepted when wr_en=1 and either full=0 or a pop occurs on the same edge.
REQ-016 A write with wr_en=1, full=1 and no same-edge pop SHALL be dropped; storage, pointers and level stay unchanged.
REQ-017 level SHALL increment on accepted write only, decrement on pop only, and stay unchanged on simultaneous write and pop.
REQ-018 full, empty and level SHALL be registered and reflect the state after the edge.
REQ-019 Feeder FSM states: IDLE, REQ, WAIT_BUSY, WAIT_DONE.
REQ-020 IDLE -> REQ when empty=0 and tx_busy=0; on that edge tx_data is loaded from mem[rd_ptr], tx_req is set to 1, and the entry is popped.
REQ-021 REQ -> WAIT_BUSY unconditionally; tx_req SHALL be cleared on that edge, so tx_req is high for exactly one cycle.
REQ-022 WAIT_BUSY -> WAIT_DONE when tx_busy=1; otherwise hold.
REQ-023 WAIT_DONE -> IDLE when tx_busy=0; otherwise hold.
REQ-024 tx_data SHALL hold its value from the REQ cycle until the next IDLE->REQ transition.
REQ-025 Latency: a write to an empty FIFO at edge N with FSM in IDLE and tx_busy=0 SHALL produce tx_req=1 in the cycle following edge N+1.
REQ-026 Back-to-back: with data queued, tx_req SHALL reassert in the second cycle after tx_busy falls.
REQ-027 Only one byte SHALL be outstanding to the transmitter at any time.
REQ-028 A write into an empty FIFO in the same cycle as an IDLE check SHALL NOT be popped until a later cycle; no read-through bypass.

Reset
REQ-029 On RST_N low: FSM=IDLE, tx_req=0, tx_data=0, pointers=0, level=0, empty=1, full=0, ovf_flag=0; FIFO contents are don't-care.
REQ-030 Reset asserted mid-transfer SHALL discard all queued bytes; the block SHALL NOT re-issue the in-flight byte after release.
REQ-031 After release, the first tx_req SHALL require a new write.

Configuration
REQ-032 Macro UART_TX_FIFO_OVF_EN.
- Defined: ovf_flag sets on any dropped write (REQ-016) and clears on ovf_clr=1; a set and a clear on the same edge leave the flag set.
- Undefined: ovf_flag is tied to 0, ovf_clr is ignored, and the overflow detection logic is not synthesised.

Verification
REQ-033 Write 0xA5 into an empty FIFO with tx_busy=0 -> tx_req high for 1 cycle carrying tx_data=0xA5; level 1 -> 0.
REQ-034 Write 0x01..0x10 (DEPTH_LOG2=4) while tx_busy is held 1 -> full=1, level=16; after tx_busy drops, bytes emerge in order 0x01..0x10, each with exactly one tx_req.
REQ-035 With FIFO full, write 0xFF with no pop -> byte dropped, level stays 16; ovf_flag=1 when the macro is defined, 0 when undefined; ovf_clr then returns ovf_flag to 0.
REQ-036 With FIFO full and FSM in IDLE with tx_busy=0, write 0x77 -> pop and write on the same edge, level stays 16, and 0x77 is the last byte emitted.
REQ-037 Assert RST_N low during WAIT_DONE with 5 bytes queued -> all outputs take reset values; after release, no tx_req appears until a new write.
REQ-038 Model the transmitter with tx_busy rising 1 cycle after tx_req and lasting 40 cycles; fill with 3 bytes -> exactly 3 tx_req pulses, with no tx_req while tx_busy=1.
